// File: rtl/selector_frecuencia_if.sv
// Index -> code lookup link between the frequency selector and the frequency code memory.
// Latency: the memory registers its output, so frecuencia is valid one edge after num_frecuencia changes.
// Backpressure: none; the requester simply waits the fixed memory latency.
// Ports: num_frecuencia (index, requester -> memory), frecuencia (8-bit code, memory -> requester).
interface selector_frecuencia_if;
    logic [2:0] num_frecuencia;
    logic [7:0] frecuencia;

    // Requesting end: drives the index, consumes the returned code.
    modport master (
        output num_frecuencia,
        input  frecuencia
    );

    // Memory end: consumes the index, returns the registered code.
    modport slave (
        input  num_frecuencia,
        output frecuencia
    );
endinterface

// File: rtl/selector_frecuencia.sv
// DPWM frequency selector: buttons step a saturating 3-bit index, the code is read from memory
// and handed to the period counter only on a PWM period boundary (glitch-free period change).
// Latency: 3 edges minimum from button edge to apply; button edges are dropped while busy.
// Ports: CLK, RST (sync, active-high), btn_up/btn_down (levels), period_end (pulse),
//        mem (index out / code in), codigo_activo, ocupado, aplicado (all registered).
module selector_frecuencia #(
    parameter logic [7:0] CODIGO_RESET = 8'd30
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        period_end,
    selector_frecuencia_if.master       mem,
    output logic [7:0]                  codigo_activo,
    output logic                        ocupado,
    output logic                        aplicado
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ESPERA_MEM = 2'd1,
        LECTURA    = 2'd2,
        PENDIENTE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       btn_up_q;
    logic       btn_down_q;
    logic       ev_up;
    logic       ev_down;
    logic       acepta_up;
    logic       acepta_down;

    logic [2:0] num_q;
    logic [2:0] num_next;
    logic [7:0] codigo_nuevo;
    logic [7:0] codigo_nuevo_next;
    logic [7:0] codigo_activo_next;
    logic       aplicado_next;

    // Rising-edge detection on the already-synchronized button levels.
    assign ev_up   = btn_up & ~btn_up_q;
    assign ev_down = btn_down & ~btn_down_q;

    // Simultaneous edges cancel; steps saturate at the index limits.
    assign acepta_up   = ev_up & ~ev_down & (num_q != 3'd7);
    assign acepta_down = ev_down & ~ev_up & (num_q != 3'd0);

    assign mem.num_frecuencia = num_q;

    // Previous button levels are tracked in every state so that a level held through
    // the busy window cannot fire later. Reset loads 1 so a held button is not an edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            btn_up_q   <= 1'b1;
            btn_down_q <= 1'b1;
        end else begin
            btn_up_q   <= btn_up;
            btn_down_q <= btn_down;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (acepta_up || acepta_down) begin
                    state_next = ESPERA_MEM;
                end
            end
            // Memory registers the code for the new index during this cycle.
            ESPERA_MEM: state_next = LECTURA;
            LECTURA:    state_next = PENDIENTE;
            PENDIENTE: begin
                if (period_end) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // FSM output logic: next values of the registered datapath.
    always_comb begin
        num_next           = num_q;
        codigo_nuevo_next  = codigo_nuevo;
        codigo_activo_next = codigo_activo;
        aplicado_next      = 1'b0;
        case (state)
            IDLE: begin
                if (acepta_up) begin
                    num_next = num_q + 3'd1;
                end else if (acepta_down) begin
                    num_next = num_q - 3'd1;
                end
            end
            ESPERA_MEM: ;
            LECTURA: begin
                codigo_nuevo_next = mem.frecuencia;
            end
            PENDIENTE: begin
                // Swap only on the last cycle of a PWM period.
                if (period_end) begin
                    codigo_activo_next = codigo_nuevo;
                    aplicado_next      = 1'b1;
                end
            end
        endcase
    end

    // Registered outputs; ocupado is registered from the next state so it matches state != IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            num_q         <= 3'd0;
            codigo_nuevo  <= 8'd0;
            codigo_activo <= CODIGO_RESET;
            aplicado      <= 1'b0;
            ocupado       <= 1'b0;
        end else begin
            num_q         <= num_next;
            codigo_nuevo  <= codigo_nuevo_next;
            codigo_activo <= codigo_activo_next;
            aplicado      <= aplicado_next;
            ocupado       <= (state_next != IDLE);
        end
    end

endmodule

// File: tb/tb_selector_frecuencia.sv
module tb_selector_frecuencia;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       btn_up = 1'b1;
    logic       btn_down = 1'b1;
    logic       period_end = 1'b0;
    logic [7:0] codigo_activo;
    logic       ocupado;
    logic       aplicado;

    int total = 0;
    int bad   = 0;
    int idx_m = 0;
    logic [7:0] sb[$];

    selector_frecuencia_if mif ();

    selector_frecuencia #(.CODIGO_RESET(8'd30)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .period_end    (period_end),
        .mem           (mif),
        .codigo_activo (codigo_activo),
        .ocupado       (ocupado),
        .aplicado      (aplicado)
    );

    always #5 CLK = ~CLK;

    // Frequency code memory contents.
    function automatic logic [7:0] code_of(input int i);
        case (i)
            0: code_of = 8'd30;
            1: code_of = 8'd50;
            2: code_of = 8'd70;
            3: code_of = 8'd100;
            4: code_of = 8'd130;
            5: code_of = 8'd160;
            6: code_of = 8'd180;
            default: code_of = 8'd200;
        endcase
    endfunction

    // Registered memory model on the slave side of the lookup link.
    always @(posedge CLK) mif.frecuencia <= code_of(int'(mif.num_frecuencia));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Scoreboard consumer: every aplicado pulse must deliver the oldest expected code.
    always @(negedge CLK) begin
        if (!RST && aplicado) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_apply", 32'(codigo_activo), 32'hFFFF_FFFF);
            end else begin
                chk("sb_code", 32'(codigo_activo), 32'(sb.pop_front()));
            end
        end
    end

    // One button step with period_end held high so the apply lands at the earliest edge (E3).
    task automatic step(input logic u, input logic d);
        bit acc;
        acc = 1'b0;
        if (u && !d && idx_m < 7) begin idx_m++; acc = 1'b1; end
        else if (d && !u && idx_m > 0) begin idx_m--; acc = 1'b1; end
        btn_up = u; btn_down = d;
        tick(1);
        btn_up = 1'b0; btn_down = 1'b0;
        chk("step_idx", 32'(mif.num_frecuencia), 32'(idx_m));
        chk("step_busy", 32'(ocupado), 32'(acc));
        if (acc) sb.push_back(code_of(idx_m));
        period_end = 1'b1;
        tick(2);
        chk("step_no_early_apply", 32'(aplicado), 32'd0);
        tick(1);
        chk("step_apply", 32'(aplicado), 32'(acc));
        chk("step_code", 32'(codigo_activo), 32'(code_of(idx_m)));
        chk("step_idle", 32'(ocupado), 32'd0);
        period_end = 1'b0;
        tick(1);
        chk("step_apply_one_cycle", 32'(aplicado), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both buttons held.
        tick(3);
        RST = 1'b0;
        tick(1);
        chk("rst_idx", 32'(mif.num_frecuencia), 32'd0);
        chk("rst_code", 32'(codigo_activo), 32'd30);
        chk("rst_busy", 32'(ocupado), 32'd0);
        chk("rst_apply", 32'(aplicado), 32'd0);
        tick(5);
        chk("held_btn_no_start", 32'(ocupado), 32'd0);
        chk("held_btn_idx", 32'(mif.num_frecuencia), 32'd0);
        btn_up = 1'b0; btn_down = 1'b0;
        tick(2);

        // Single up press, period_end arriving 10 cycles later.
        btn_up = 1'b1;
        tick(1);
        btn_up = 1'b0;
        idx_m = 1;
        sb.push_back(8'd50);
        chk("up_idx_e0", 32'(mif.num_frecuencia), 32'd1);
        chk("up_busy_e0", 32'(ocupado), 32'd1);
        tick(9);
        chk("up_code_held", 32'(codigo_activo), 32'd30);
        chk("up_still_busy", 32'(ocupado), 32'd1);
        period_end = 1'b1;
        tick(1);
        period_end = 1'b0;
        chk("up_apply", 32'(aplicado), 32'd1);
        chk("up_code", 32'(codigo_activo), 32'd50);
        chk("up_idle", 32'(ocupado), 32'd0);
        tick(1);
        chk("up_apply_pulse", 32'(aplicado), 32'd0);

        // Back to index 0, down at 0 ignored, then 8 ups saturating at 7.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk("sat_idx", 32'(mif.num_frecuencia), 32'd7);
        chk("sat_code", 32'(codigo_activo), 32'd200);

        // Both buttons rising together.
        step(1'b1, 1'b1);

        // Down to 5, then an up with period_end in ESPERA_MEM and a second up edge in PENDIENTE.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        btn_up = 1'b1;
        tick(1);
        btn_up = 1'b0;
        idx_m = 6;
        sb.push_back(code_of(6));
        period_end = 1'b1;
        tick(1);
        period_end = 1'b0;
        chk("pe_in_espera_ignored", 32'(aplicado), 32'd0);
        tick(1);
        btn_up = 1'b1;
        tick(1);
        chk("pend_idx", 32'(mif.num_frecuencia), 32'd6);
        chk("pend_busy", 32'(ocupado), 32'd1);
        chk("pend_no_apply", 32'(aplicado), 32'd0);
        btn_up = 1'b0;
        tick(2);
        chk("pend_waiting", 32'(ocupado), 32'd1);
        period_end = 1'b1;
        tick(1);
        period_end = 1'b0;
        chk("pend_apply", 32'(aplicado), 32'd1);
        chk("pend_code", 32'(codigo_activo), 32'd180);
        tick(3);
        chk("pend_single_step", 32'(mif.num_frecuencia), 32'd6);
        chk("pend_no_restart", 32'(ocupado), 32'd0);

        // Reach PENDIENTE at index 3 (code 100), then reset mid-transaction.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        btn_down = 1'b1;
        tick(1);
        btn_down = 1'b0;
        tick(3);
        chk("mid_idx", 32'(mif.num_frecuencia), 32'd3);
        chk("mid_busy", 32'(ocupado), 32'd1);
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        idx_m = 0;
        chk("mid_rst_idx", 32'(mif.num_frecuencia), 32'd0);
        chk("mid_rst_code", 32'(codigo_activo), 32'd30);
        chk("mid_rst_busy", 32'(ocupado), 32'd0);
        period_end = 1'b1;
        tick(1);
        period_end = 1'b0;
        chk("mid_rst_no_apply", 32'(aplicado), 32'd0);
        tick(2);
        chk("mid_rst_no_apply_late", 32'(aplicado), 32'd0);
        chk("mid_rst_code_kept", 32'(codigo_activo), 32'd30);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
